// File: rtl/seq_match_ctrl_if.sv
// Host-side bundle for seq_match_ctrl: configuration, scan control,
// serial sample input and match/status outputs.
interface seq_match_ctrl_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic [CNT_W-1:0]   cfg_target;
   logic               start;
   logic               x_valid;
   logic               x;
   logic               busy;
   logic               hit;
   logic [CNT_W-1:0]   match_count;
   logic               done;
   logic               cfg_err;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      output start, x_valid, x,
      input  busy, hit, match_count, done, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      input  start, x_valid, x,
      output busy, hit, match_count, done, cfg_err
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern-match controller. Scans a qualified bit
// stream for a runtime-configured pattern, counts matches and stops when
// the target count is reached.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   S_IDLE | not scanning; configuration writes and start accepted
//   S_RUN  | scanning; samples accepted, configuration writes ignored
//   S_DONE | target reached; holds count until start or cfg write
module seq_match_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input logic             clk,
   input logic             reset,
   seq_match_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               hit_q;
   logic               done_q;
   logic               err_q;

   logic [MAX_LEN-1:0] hist_d;
   logic [LEN_W-1:0]   fill_d;
   logic [CNT_W-1:0]   cnt_d;
   logic [MAX_LEN-1:0] len_mask;
   logic               is_match;
   logic               cfg_bad;

   // Post-shift history/fill and the match test against the stored pattern.
   // fill gates the compare, so stale history after a non-overlap hit is
   // never seen.
   always_comb begin
      hist_d   = {hist_q[MAX_LEN-2:0], bus.x};
      fill_d   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      len_mask = ~({MAX_LEN{1'b1}} << len_q);
      is_match = (fill_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
      cfg_bad  = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));
   end

   // Control FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         len_q   <= LEN_W'(1);
         ovl_q   <= 1'b0;
         tgt_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hit_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         hit_q <= 1'b0;
         case (state_q)
            S_RUN: begin
               if (bus.start) begin
                  hist_q <= '0;
                  fill_q <= '0;
                  cnt_q  <= '0;
               end else if (bus.x_valid) begin
                  hist_q <= hist_d;
                  if (is_match) begin
                     hit_q  <= 1'b1;
                     cnt_q  <= cnt_d;
                     fill_q <= ovl_q ? fill_d : '0;
                     if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     fill_q <= fill_d;
                  end
               end
            end
            default: begin
               // A configuration write always beats a same-cycle start.
               if (bus.cfg_we) begin
                  pat_q   <= bus.cfg_pattern;
                  len_q   <= bus.cfg_len;
                  ovl_q   <= bus.cfg_overlap;
                  tgt_q   <= bus.cfg_target;
                  err_q   <= cfg_bad;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else if (bus.start && !err_q) begin
                  hist_q  <= '0;
                  fill_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.hit         = hit_q;
   assign bus.match_count = cnt_q;
   assign bus.done        = done_q;
   assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_seq_match_ctrl;
   localparam int MAXL    = 8;
   localparam int LW      = 4;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DONE  = 2;

   logic clk;
   logic reset;

   seq_match_ctrl_if #(.MAX_LEN(MAXL), .LEN_W(LW), .CNT_W(CW)) bus ();

   seq_match_ctrl #(.MAX_LEN(MAXL), .LEN_W(LW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int hit_tally = 0;

   // reference model state
   int         m_mode;
   int         m_cnt;
   bit         m_hit;
   bit         m_err;
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_tgt;
   bit         m_bits[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Matching is judged on the list of samples accepted since the last
   // clear: the newest m_len samples must equal the pattern, MSB first.
   task automatic model_step();
      bit ok;
      int n;
      m_hit = 1'b0;
      if (reset) begin
         m_mode = M_IDLE; m_cnt = 0; m_err = 1'b0;
         m_pat = 8'h00; m_len = 1; m_ovl = 1'b0; m_tgt = 0;
         m_bits.delete();
      end else if (m_mode != M_RUN) begin
         if (bus.cfg_we) begin
            m_pat = bus.cfg_pattern;
            m_len = int'(bus.cfg_len);
            m_ovl = bus.cfg_overlap;
            m_tgt = int'(bus.cfg_target);
            m_err = (m_len == 0) || (m_len > MAXL);
            m_mode = M_IDLE;
         end else if (bus.start && !m_err) begin
            m_bits.delete();
            m_cnt = 0;
            m_mode = M_RUN;
         end
      end else begin
         if (bus.start) begin
            m_bits.delete();
            m_cnt = 0;
         end else if (bus.x_valid) begin
            m_bits.push_back(bus.x);
            if (m_bits.size() > MAXL) void'(m_bits.pop_front());
            n = m_bits.size();
            ok = (n >= m_len);
            if (ok)
               for (int i = 0; i < m_len; i++)
                  if (m_bits[n-1-i] != m_pat[i]) ok = 1'b0;
            if (ok) begin
               m_hit = 1'b1;
               if (m_cnt < CNT_MAX) m_cnt++;
               if (!m_ovl) m_bits.delete();
               if (m_tgt != 0 && m_cnt == m_tgt) m_mode = M_DONE;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (bus.hit === 1'b1) hit_tally++;
      chk("hit",   32'(bus.hit),         32'(m_hit));
      chk("count", 32'(bus.match_count), 32'(m_cnt));
      chk("busy",  32'(bus.busy),        32'(m_mode == M_RUN));
      chk("done",  32'(bus.done),        32'(m_mode == M_DONE));
      chk("err",   32'(bus.cfg_err),     32'(m_err));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
      bus.cfg_overlap = o;
      bus.cfg_target  = t;
      bus.cfg_we      = 1'b1;
      tick();
      bus.cfg_we      = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input bit b, input int gap);
      bus.x_valid = 1'b1;
      bus.x       = b;
      tick();
      bus.x_valid = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin
      logic [6:0] s7;
      reset           = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_overlap = 1'b0;
      bus.cfg_target  = '0;
      bus.start       = 1'b0;
      bus.x_valid     = 1'b0;
      bus.x           = 1'b0;

      // reset state
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_count", 32'(bus.match_count), 32'd0);

      // overlap scan 010 over 0101010
      do_cfg(8'b010, 4'd3, 1'b1, 8'd0);
      do_start();
      chk("start_busy", 32'(bus.busy), 32'd1);
      s7 = 7'b0101010;
      hit_tally = 0;
      for (int i = 6; i >= 0; i--) send(s7[i], 0);
      tick();
      chk("ovl_hits",  32'(hit_tally), 32'd3);
      chk("ovl_count", 32'(bus.match_count), 32'd3);

      // non-overlap scan
      do_reset();
      do_cfg(8'b010, 4'd3, 1'b0, 8'd0);
      do_start();
      hit_tally = 0;
      for (int i = 6; i >= 0; i--) send(s7[i], 0);
      tick();
      chk("novl_hits",  32'(hit_tally), 32'd2);
      chk("novl_count", 32'(bus.match_count), 32'd2);

      // target stop
      do_reset();
      do_cfg(8'b11, 4'd2, 1'b1, 8'd2);
      do_start();
      hit_tally = 0;
      for (int i = 0; i < 5; i++) send(1'b1, 0);
      chk("tgt_hits",  32'(hit_tally), 32'd2);
      chk("tgt_count", 32'(bus.match_count), 32'd2);
      chk("tgt_done",  32'(bus.done), 32'd1);
      chk("tgt_busy",  32'(bus.busy), 32'd0);
      do_cfg(8'b1, 4'd1, 1'b0, 8'd0);
      chk("cfg_clears_done", 32'(bus.done), 32'd0);

      // illegal configurations
      do_cfg(8'h00, 4'd0, 1'b0, 8'd0);
      chk("err_len0", 32'(bus.cfg_err), 32'd1);
      do_start();
      chk("err_no_run", 32'(bus.busy), 32'd0);
      do_cfg(8'h00, 4'd9, 1'b0, 8'd0);
      chk("err_len9", 32'(bus.cfg_err), 32'd1);
      do_cfg(8'h0A, 4'd4, 1'b0, 8'd0);
      chk("err_clear", 32'(bus.cfg_err), 32'd0);
      do_start();
      chk("legal_run", 32'(bus.busy), 32'd1);

      // cfg_we beats start in the same cycle
      do_reset();
      bus.start = 1'b1;
      do_cfg(8'b1, 4'd1, 1'b1, 8'd0);
      bus.start = 1'b0;
      chk("we_beats_start", 32'(bus.busy), 32'd0);

      // gapped input, then restart mid-pattern
      do_reset();
      do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
      do_start();
      hit_tally = 0;
      send(1'b1, 2); send(1'b0, 2); send(1'b1, 2);
      chk("gap_hits", 32'(hit_tally), 32'd1);
      send(1'b1, 0); send(1'b0, 0);
      do_start();
      send(1'b1, 0);
      tick();
      chk("restart_hits", 32'(hit_tally), 32'd1);

      // reset mid-run, then start with default configuration
      do_reset();
      do_cfg(8'b1, 4'd1, 1'b1, 8'd0);
      do_start();
      send(1'b1, 0); send(1'b1, 0);
      chk("pre_rst_count", 32'(bus.match_count), 32'd2);
      do_reset();
      chk("midrst_busy",  32'(bus.busy), 32'd0);
      chk("midrst_count", 32'(bus.match_count), 32'd0);
      do_start();
      hit_tally = 0;
      send(1'b0, 0); send(1'b1, 0); send(1'b0, 0);
      tick();
      chk("default_hits", 32'(hit_tally), 32'd2);

      // random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset           = ($urandom_range(0, 299) == 0);
         bus.cfg_we      = ($urandom_range(0, 29) == 0);
         bus.cfg_pattern = 8'($urandom);
         bus.cfg_len     = 4'($urandom_range(0, 9) < 8 ? $urandom_range(1, 4) : $urandom_range(0, 15));
         bus.cfg_overlap = 1'($urandom);
         bus.cfg_target  = 8'($urandom_range(0, 5));
         bus.start       = ($urandom_range(0, 39) == 0);
         bus.x_valid     = ($urandom_range(0, 3) != 0);
         bus.x           = 1'($urandom);
         tick();
      end
      reset       = 1'b0;
      bus.cfg_we  = 1'b0;
      bus.start   = 1'b0;
      bus.x_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial pattern-match controller for the FSM detector family. It holds a runtime-configured pattern of 1 to MAX_LEN bits and an overlap mode, then scans a qualified serial bit stream. Each match is counted, and the block stops when a target count is reached. Host logic uses it in place of hard-coded detectors such as fixed 010 Moore machines, arming and disarming it through a start/done handshake.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- LEN_W, 4: width of cfg_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: match counter width.

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  configuration write strobe.
- cfg_pattern  input  MAX_LEN  pattern. Bit [cfg_len-1] is the first serial bit and bit [0] is the last.
- cfg_len  input  LEN_W  pattern length; legal range is 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches, 0 = history cleared after each hit.
- cfg_target  input  CNT_W  number of matches to stop at; 0 = run until the next start or reset.
- start  input  1  arms or re-arms the scan.
- x_valid  input  1  qualifies x this cycle.
- x  input  1  serial data bit.
- busy  output  1  high in RUN.
- hit  output  1  one-cycle pulse per match.
- match_count  output  CNT_W  matches found since the last start; saturates at all-ones.
- done  output  1  high in DONE (target reached).
- cfg_err  output  1  sticky flag; stored configuration is illegal.

## Operation
- States: IDLE, RUN, DONE.
- Registers: pat_r, len_r, ovl_r, tgt_r (configuration); hist (MAX_LEN-bit shift register; the newest bit is hist[0]); fill (0..MAX_LEN, saturating); cnt.
- cfg_we:
  - Accepted only in IDLE or DONE; ignored in RUN.
  - Loads all cfg_* fields.
  - Sets cfg_err = (cfg_len == 0 || cfg_len > MAX_LEN). Otherwise clears it.
  - In DONE it also returns the block to IDLE.
- start:
  - In IDLE or DONE with cfg_err = 0 and cfg_we = 0: clears hist, fill and cnt, then enters RUN.
  - In RUN: restarts the scan. Clears hist, fill and cnt, stays in RUN, and discards that cycle's sample.
  - Ignored when cfg_err = 1.
  - cfg_we and start in the same cycle: cfg_we wins and start is dropped.
- Sample acceptance: a sample is accepted when x_valid = 1 in RUN and there is no start that cycle. On acceptance, hist <= {hist, x} and fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift values: fill' >= len_r, and the low len_r bits of hist' equal the low len_r bits of pat_r.
- On a match:
  - hit pulses.
  - cnt increments unless it is already all-ones.
  - If ovl_r = 0, fill is cleared to 0 instead of incremented. hist still shifts, but its contents are masked by fill.
- Termination: if tgt_r != 0 and the new cnt equals tgt_r, the block enters DONE. No samples are accepted in DONE.
- Reset values: state IDLE; busy = 0, hit = 0, done = 0, cfg_err = 0, match_count = 0. Configuration registers reset to pattern 0, length 1, overlap 0, target 0.
- Reset mid-RUN aborts immediately and takes priority over every other input.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- hit, match_count and the DONE entry all update at the same edge that accepts the completing bit. They are visible in the following cycle.
- Latency from the final pattern bit (x_valid high) to hit high is 1 cycle.
- busy rises 1 cycle after start is sampled. It falls in the same cycle that done rises.
- done stays high until the next accepted start, an accepted cfg_we, or reset.
- x_valid gaps of any length leave hist and fill unchanged. A match may span a gap.
- Throughput: one sample per cycle. Back-to-back hits are possible when ovl_r = 1 and len_r = 1.

## Test plan
- Overlap scan: pattern 010 (len 3), overlap = 1, target = 0. Stream 0,1,0,1,0,1,0 with continuous valid -> 3 hit pulses, one cycle after the 3rd, 5th and 7th bits; match_count = 3.
- Non-overlap scan: same pattern and stream with overlap = 0 -> 2 hits, after the 3rd and 7th bits; match_count = 2.
- Target stop: pattern 11, overlap = 1, target = 2. Stream 1,1,1,1,1 -> hits after bits 2 and 3. done rises and busy falls in the same cycle. Bits 4 and 5 are ignored; match_count stays 2.
- Illegal config: cfg_len = 0, then start -> cfg_err = 1 and the block stays in IDLE. Rewrite with cfg_len = 9 (MAX_LEN = 8) -> cfg_err stays 1. Rewrite with cfg_len = 4 -> cfg_err = 0, and start enters RUN.
- Gapped input and restart: pattern 101 with x_valid pulsed every 3rd cycle -> exactly 1 hit. Then assert start mid-pattern after bits 1,0 -> fill clears, so subsequent bits 1 alone produce no hit.
- Reset mid-RUN: after 2 matches, assert reset for 1 cycle -> next cycle has state IDLE with all outputs 0. A subsequent start without cfg_we uses the default length-1 pattern 0.
